// File: rtl/sh7604_line_fill_pkg.sv
// Shared types and helpers for the SH7604 cache line-fill engine.
package sh7604_line_fill_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } LineFillState_t;

  localparam int LINE_WORDS = 4;

  // Word index of a beat within the line: (start + beat) mod 4.
  function automatic logic [1:0] wrap_idx(input logic [1:0] start, input logic [1:0] beat);
    return start + beat;
  endfunction

endpackage

// File: rtl/sh7604_line_buf.sv
// 4x32 line buffer: one word-indexed write port, whole line read as 128 bits (word 0 in the MSBs).
module sh7604_line_buf
  import sh7604_line_fill_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         we_i,
  input  logic [1:0]   idx_i,
  input  logic [31:0]  wdata_i,
  output logic [127:0] line_o
);

  logic [31:0] mem_q [LINE_WORDS];

  // NOTE: this small buffer is reset on purpose so LINE_DATA reads 0 after reset;
  // a large RAM would normally be left unreset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LINE_WORDS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < LINE_WORDS; i++) line_o[127-32*i -: 32] = mem_q[i];
  end

endmodule

// File: rtl/sh7604_line_fill.sv
// SH7604 cache-miss line-fill engine: 4-beat burst fills or single reads on DBUS.
// Define LINE_FILL_CWF_EN to enable critical-word-first ordering (selected by ORDER_WRAP).
module sh7604_line_fill
  import sh7604_line_fill_pkg::*;
#(
  parameter int WAY_W      = 2,
  parameter int ORDER_WRAP = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE_R,
  input  logic             MISS_REQ,
  input  logic [31:0]      MISS_A,
  input  logic             MISS_CACHEABLE,
  input  logic [WAY_W-1:0] MISS_WAY,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             CRIT_VALID,
  output logic [31:0]      CRIT_DATA,
  output logic             LINE_VALID,
  output logic [127:0]     LINE_DATA,
  output logic [27:0]      LINE_A,
  output logic [WAY_W-1:0] LINE_WAY,
  output logic [31:0]      DBUS_A,
  output logic             DBUS_REQ,
  output logic             DBUS_BURST,
  output logic             DBUS_WE,
  output logic [3:0]       DBUS_BA,
  output logic             DBUS_LOCK,
  input  logic [31:0]      DBUS_DI,
  input  logic             DBUS_BUSY
);

`ifdef LINE_FILL_CWF_EN
  localparam bit CwfEn = 1'b1;
`else
  localparam bit CwfEn = 1'b0;
`endif

  LineFillState_t   state_q;
  logic [1:0]       beat_q, start_q, crit_idx_q;
  logic             cacheable_q, busy_q;
  logic             dbus_req_q, dbus_burst_q, dbus_lock_q;
  logic             crit_valid_q, line_valid_q;
  logic [31:0]      crit_data_q;
  logic [27:0]      line_a_q;
  logic [WAY_W-1:0] way_q;

  logic [1:0] start_d, beat_d, idx;
  logic       beat_done, buf_we;
  logic       unused_miss_lsb;

  // A single read must fetch the missed word itself, whatever the line order.
  assign start_d   = (!MISS_CACHEABLE || (CwfEn && ORDER_WRAP != 0)) ? MISS_A[3:2] : 2'd0;
  assign beat_d    = beat_q + 2'd1;
  assign idx       = wrap_idx(start_q, beat_q);
  assign beat_done = dbus_req_q && !DBUS_BUSY;
  assign buf_we    = CE_R && (state_q == REQ) && beat_done;
  assign unused_miss_lsb = ^MISS_A[1:0];

  // NOTE: all state updates use non-blocking assignments so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      start_q      <= '0;
      crit_idx_q   <= '0;
      cacheable_q  <= 1'b0;
      busy_q       <= 1'b0;
      dbus_req_q   <= 1'b0;
      dbus_burst_q <= 1'b0;
      dbus_lock_q  <= 1'b0;
      crit_valid_q <= 1'b0;
      line_valid_q <= 1'b0;
      crit_data_q  <= '0;
      line_a_q     <= '0;
      way_q        <= '0;
    end else if (CE_R) begin
      crit_valid_q <= 1'b0;
      line_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (MISS_REQ) begin
            line_a_q     <= MISS_A[31:4];
            way_q        <= MISS_WAY;
            cacheable_q  <= MISS_CACHEABLE;
            crit_idx_q   <= MISS_A[3:2];
            start_q      <= start_d;
            beat_q       <= '0;
            busy_q       <= 1'b1;
            dbus_req_q   <= 1'b1;
            dbus_burst_q <= MISS_CACHEABLE;
            dbus_lock_q  <= MISS_CACHEABLE;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (beat_done) begin
            beat_q <= beat_d;
            if (idx == crit_idx_q) begin
              crit_data_q  <= DBUS_DI;
              crit_valid_q <= 1'b1;
            end
          end
          // Abort wins over a normal finish: no LINE_VALID for a purged fill.
          if (ABORT) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            dbus_req_q   <= 1'b0;
            dbus_burst_q <= 1'b0;
            dbus_lock_q  <= 1'b0;
          end else if (beat_done && (beat_q == 2'd3 || !cacheable_q)) begin
            state_q      <= DONE;
            dbus_req_q   <= 1'b0;
            dbus_burst_q <= 1'b0;
            dbus_lock_q  <= 1'b0;
            line_valid_q <= cacheable_q;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sh7604_line_buf u_line_buf (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (buf_we),
    .idx_i   (idx),
    .wdata_i (DBUS_DI),
    .line_o  (LINE_DATA)
  );

  assign BUSY       = busy_q;
  assign CRIT_VALID = crit_valid_q;
  assign CRIT_DATA  = crit_data_q;
  assign LINE_VALID = line_valid_q;
  assign LINE_A     = line_a_q;
  assign LINE_WAY   = way_q;
  assign DBUS_A     = dbus_req_q ? {line_a_q, idx, 2'b00} : 32'd0;
  assign DBUS_REQ   = dbus_req_q;
  assign DBUS_BURST = dbus_burst_q;
  assign DBUS_WE    = 1'b0;
  assign DBUS_BA    = 4'b1111;
  assign DBUS_LOCK  = dbus_lock_q;

endmodule

// File: tb/tb_sh7604_line_fill.sv
// Directed bench for sh7604_line_fill; expectations follow the LINE_FILL_CWF_EN build setting.
module tb_sh7604_line_fill;
  localparam int WAY_W = 2;
`ifdef LINE_FILL_CWF_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST, CE_R, MISS_REQ, MISS_CACHEABLE, ABORT, DBUS_BUSY;
  logic [31:0] MISS_A, DBUS_DI;
  logic [WAY_W-1:0] MISS_WAY;
  logic BUSY, CRIT_VALID, LINE_VALID, DBUS_REQ, DBUS_BURST, DBUS_WE, DBUS_LOCK;
  logic [31:0] CRIT_DATA, DBUS_A;
  logic [127:0] LINE_DATA;
  logic [27:0] LINE_A;
  logic [WAY_W-1:0] LINE_WAY;
  logic [3:0] DBUS_BA;

  int n_cmp = 0;
  int n_err = 0;

  sh7604_line_fill #(.WAY_W(WAY_W), .ORDER_WRAP(1)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R), .MISS_REQ(MISS_REQ), .MISS_A(MISS_A),
    .MISS_CACHEABLE(MISS_CACHEABLE), .MISS_WAY(MISS_WAY), .ABORT(ABORT),
    .BUSY(BUSY), .CRIT_VALID(CRIT_VALID), .CRIT_DATA(CRIT_DATA), .LINE_VALID(LINE_VALID),
    .LINE_DATA(LINE_DATA), .LINE_A(LINE_A), .LINE_WAY(LINE_WAY), .DBUS_A(DBUS_A),
    .DBUS_REQ(DBUS_REQ), .DBUS_BURST(DBUS_BURST), .DBUS_WE(DBUS_WE), .DBUS_BA(DBUS_BA),
    .DBUS_LOCK(DBUS_LOCK), .DBUS_DI(DBUS_DI), .DBUS_BUSY(DBUS_BUSY)
  );

  always #5 CLK = ~CLK;

  // The cache side must never request a fill while one is in progress.
  always @(posedge CLK)
    if (!RST && CE_R && MISS_REQ) assert (!BUSY) else $error("protocol: MISS_REQ while BUSY");

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic c, input logic [WAY_W-1:0] w);
    MISS_A = a; MISS_CACHEABLE = c; MISS_WAY = w; MISS_REQ = 1'b1;
    step();
    MISS_REQ = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(); step();
    n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    n_cmp++; if (DBUS_REQ !== 1'b0 || DBUS_LOCK !== 1'b0 || DBUS_BURST !== 1'b0 || DBUS_WE !== 1'b0)
      begin n_err++; $display("FAIL reset_dbus_ctl: got req=%b lock=%b burst=%b we=%b want 0", DBUS_REQ, DBUS_LOCK, DBUS_BURST, DBUS_WE); end
    n_cmp++; if (DBUS_A !== 32'd0) begin n_err++; $display("FAIL reset_dbus_a: got %h want 0", DBUS_A); end
    n_cmp++; if (CRIT_VALID !== 1'b0 || LINE_VALID !== 1'b0)
      begin n_err++; $display("FAIL reset_pulses: got crit=%b line=%b want 0", CRIT_VALID, LINE_VALID); end
    n_cmp++; if (LINE_DATA !== 128'd0 || CRIT_DATA !== 32'd0 || LINE_A !== 28'd0 || LINE_WAY !== '0)
      begin n_err++; $display("FAIL reset_data: got line=%h crit=%h a=%h way=%h want 0", LINE_DATA, CRIT_DATA, LINE_A, LINE_WAY); end
    n_cmp++; if (DBUS_BA !== 4'b1111) begin n_err++; $display("FAIL dbus_ba: got %h want f", DBUS_BA); end
    RST = 1'b0;
    step();
  endtask

  task automatic test_cacheable();
    logic [31:0] di [4];
    logic [31:0] exp_a [4];
    logic [127:0] exp_line;
    logic [31:0] exp_crit;
    int exp_crit_beat;
    int lock_cnt = 0, crit_cnt = 0, crit_at = -1, line_cnt = 0;
    di = '{32'h11, 32'h22, 32'h33, 32'h44};
    if (WRAP) begin
      exp_a = '{32'h0600_0008, 32'h0600_000C, 32'h0600_0000, 32'h0600_0004};
      exp_line = {32'h33, 32'h44, 32'h11, 32'h22}; exp_crit = 32'h11; exp_crit_beat = 0;
    end else begin
      exp_a = '{32'h0600_0000, 32'h0600_0004, 32'h0600_0008, 32'h0600_000C};
      exp_line = {32'h11, 32'h22, 32'h33, 32'h44}; exp_crit = 32'h33; exp_crit_beat = 2;
    end
    issue(32'h0600_0008, 1'b1, 2'd2);
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (DBUS_A !== exp_a[b] || DBUS_REQ !== 1'b1 || DBUS_BURST !== 1'b1)
        begin n_err++; $display("FAIL cache_beat%0d: got a=%h req=%b burst=%b want a=%h req=1 burst=1", b, DBUS_A, DBUS_REQ, DBUS_BURST, exp_a[b]); end
      if (DBUS_LOCK) lock_cnt++;
      DBUS_DI = di[b];
      step();
      if (CRIT_VALID) begin crit_cnt++; crit_at = b; end
      if (LINE_VALID) line_cnt++;
    end
    DBUS_DI = '0;
    n_cmp++; if (DBUS_REQ !== 1'b0 || DBUS_LOCK !== 1'b0 || DBUS_BURST !== 1'b0 || BUSY !== 1'b1)
      begin n_err++; $display("FAIL cache_done: got req=%b lock=%b burst=%b busy=%b want 0 0 0 1", DBUS_REQ, DBUS_LOCK, DBUS_BURST, BUSY); end
    n_cmp++; if (LINE_VALID !== 1'b1) begin n_err++; $display("FAIL cache_line_valid: got %b want 1", LINE_VALID); end
    step();
    n_cmp++; if (BUSY !== 1'b0 || LINE_VALID !== 1'b0)
      begin n_err++; $display("FAIL cache_idle: got busy=%b line_valid=%b want 0 0", BUSY, LINE_VALID); end
    n_cmp++; if (lock_cnt !== 4) begin n_err++; $display("FAIL cache_lock_beats: got %0d want 4", lock_cnt); end
    n_cmp++; if (crit_cnt !== 1 || crit_at !== exp_crit_beat)
      begin n_err++; $display("FAIL cache_crit_timing: got count=%0d beat=%0d want 1 %0d", crit_cnt, crit_at, exp_crit_beat); end
    n_cmp++; if (line_cnt !== 1) begin n_err++; $display("FAIL cache_line_count: got %0d want 1", line_cnt); end
    n_cmp++; if (CRIT_DATA !== exp_crit) begin n_err++; $display("FAIL cache_crit_data: got %h want %h", CRIT_DATA, exp_crit); end
    n_cmp++; if (LINE_DATA !== exp_line) begin n_err++; $display("FAIL cache_line_data: got %h want %h", LINE_DATA, exp_line); end
    n_cmp++; if (LINE_A !== 28'h060_0000 || LINE_WAY !== 2'd2)
      begin n_err++; $display("FAIL cache_tag: got a=%h way=%h want 0600000 2", LINE_A, LINE_WAY); end
  endtask

  task automatic test_noncacheable();
    issue(32'h2000_0004, 1'b0, 2'd1);
    n_cmp++; if (DBUS_A !== 32'h2000_0004 || DBUS_REQ !== 1'b1 || DBUS_BURST !== 1'b0 || DBUS_LOCK !== 1'b0)
      begin n_err++; $display("FAIL nc_beat: got a=%h req=%b burst=%b lock=%b want 20000004 1 0 0", DBUS_A, DBUS_REQ, DBUS_BURST, DBUS_LOCK); end
    DBUS_DI = 32'hCAFE_0004;
    step();
    DBUS_DI = '0;
    n_cmp++; if (CRIT_VALID !== 1'b1 || CRIT_DATA !== 32'hCAFE_0004)
      begin n_err++; $display("FAIL nc_crit: got valid=%b data=%h want 1 cafe0004", CRIT_VALID, CRIT_DATA); end
    n_cmp++; if (DBUS_REQ !== 1'b0 || LINE_VALID !== 1'b0 || BUSY !== 1'b1)
      begin n_err++; $display("FAIL nc_done: got req=%b line_valid=%b busy=%b want 0 0 1", DBUS_REQ, LINE_VALID, BUSY); end
    step();
    n_cmp++; if (BUSY !== 1'b0 || LINE_VALID !== 1'b0 || LINE_WAY !== 2'd1)
      begin n_err++; $display("FAIL nc_idle: got busy=%b line_valid=%b way=%h want 0 0 1", BUSY, LINE_VALID, LINE_WAY); end
  endtask

  task automatic test_bus_stall();
    logic [31:0] exp_a [4];
    exp_a = '{32'h0600_0010, 32'h0600_0014, 32'h0600_0018, 32'h0600_001C};
    issue(32'h0600_0010, 1'b1, 2'd0);
    DBUS_DI = 32'hA0; step();
    DBUS_BUSY = 1'b1; DBUS_DI = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (DBUS_A !== exp_a[1] || DBUS_REQ !== 1'b1)
        begin n_err++; $display("FAIL stall_hold%0d: got a=%h req=%b want %h 1", i, DBUS_A, DBUS_REQ, exp_a[1]); end
    end
    DBUS_BUSY = 1'b0;
    for (int b = 1; b < 4; b++) begin
      n_cmp++; if (DBUS_A !== exp_a[b]) begin n_err++; $display("FAIL stall_beat%0d: got %h want %h", b, DBUS_A, exp_a[b]); end
      DBUS_DI = 32'hA0 + b; step();
    end
    DBUS_DI = '0;
    n_cmp++; if (LINE_VALID !== 1'b1 || LINE_DATA !== {32'hA0, 32'hA1, 32'hA2, 32'hA3} || CRIT_DATA !== 32'hA0)
      begin n_err++; $display("FAIL stall_line: got valid=%b line=%h crit=%h want 1 a0a1a2a3 a0", LINE_VALID, LINE_DATA, CRIT_DATA); end
    step();
  endtask

  task automatic test_ce_hold();
    issue(32'h0600_0040, 1'b1, 2'd3);
    DBUS_DI = 32'hB0; step();
    n_cmp++; if (CRIT_VALID !== 1'b1) begin n_err++; $display("FAIL ce_crit_pulse: got %b want 1", CRIT_VALID); end
    CE_R = 1'b0; DBUS_DI = 32'hBAD0_BAD0;
    step(); step();
    n_cmp++; if (CRIT_VALID !== 1'b1 || DBUS_A !== 32'h0600_0044 || BUSY !== 1'b1)
      begin n_err++; $display("FAIL ce_hold: got crit=%b a=%h busy=%b want 1 06000044 1", CRIT_VALID, DBUS_A, BUSY); end
    CE_R = 1'b1;
    for (int b = 1; b < 4; b++) begin DBUS_DI = 32'hB0 + b; step(); end
    DBUS_DI = '0;
    n_cmp++; if (LINE_VALID !== 1'b1 || LINE_DATA !== {32'hB0, 32'hB1, 32'hB2, 32'hB3})
      begin n_err++; $display("FAIL ce_line: got valid=%b line=%h want 1 b0b1b2b3", LINE_VALID, LINE_DATA); end
    step();
  endtask

  task automatic test_abort();
    int extra = 0;
    issue(32'h0600_0020, 1'b1, 2'd0);
    DBUS_DI = 32'hC0; step();
    DBUS_DI = 32'hC1; step();
    n_cmp++; if (DBUS_A !== 32'h0600_0028) begin n_err++; $display("FAIL abort_beat2_addr: got %h want 06000028", DBUS_A); end
    DBUS_BUSY = 1'b1; ABORT = 1'b1;
    step();
    DBUS_BUSY = 1'b0; ABORT = 1'b0;
    n_cmp++; if (BUSY !== 1'b0 || DBUS_REQ !== 1'b0 || DBUS_LOCK !== 1'b0 || LINE_VALID !== 1'b0)
      begin n_err++; $display("FAIL abort_stop: got busy=%b req=%b lock=%b line_valid=%b want 0", BUSY, DBUS_REQ, DBUS_LOCK, LINE_VALID); end
    for (int i = 0; i < 4; i++) begin step(); if (DBUS_REQ || LINE_VALID || BUSY) extra++; end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_fill();
    issue(32'h0600_0030, 1'b1, 2'd2);
    DBUS_DI = 32'hD0; step();
    RST = 1'b1; step(); RST = 1'b0;
    n_cmp++; if (BUSY !== 1'b0 || DBUS_REQ !== 1'b0 || DBUS_LOCK !== 1'b0 || DBUS_BURST !== 1'b0 || DBUS_A !== 32'd0)
      begin n_err++; $display("FAIL rst_mid_bus: got busy=%b req=%b lock=%b burst=%b a=%h want 0", BUSY, DBUS_REQ, DBUS_LOCK, DBUS_BURST, DBUS_A); end
    n_cmp++; if (LINE_DATA !== 128'd0 || CRIT_DATA !== 32'd0 || LINE_A !== 28'd0 || LINE_WAY !== '0 || CRIT_VALID !== 1'b0)
      begin n_err++; $display("FAIL rst_mid_data: got line=%h crit=%h a=%h way=%h want 0", LINE_DATA, CRIT_DATA, LINE_A, LINE_WAY); end
    issue(32'h0000_0000, 1'b1, 2'd1);
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (DBUS_A !== 32'(4 * b)) begin n_err++; $display("FAIL rst_new_beat%0d: got %h want %h", b, DBUS_A, 4 * b); end
      DBUS_DI = 32'hE0 + b; step();
    end
    DBUS_DI = '0;
    n_cmp++; if (LINE_VALID !== 1'b1 || LINE_DATA !== {32'hE0, 32'hE1, 32'hE2, 32'hE3} || CRIT_DATA !== 32'hE0)
      begin n_err++; $display("FAIL rst_new_line: got valid=%b line=%h crit=%h want 1 e0e1e2e3 e0", LINE_VALID, LINE_DATA, CRIT_DATA); end
    step();
  endtask

  task automatic test_crit_order();
    logic [31:0] exp_a [4];
    logic [31:0] exp_crit;
    int exp_crit_beat, crit_at = -1, line_at = -1;
    if (WRAP) begin
      exp_a = '{32'h0600_000C, 32'h0600_0000, 32'h0600_0004, 32'h0600_0008};
      exp_crit = 32'hF0; exp_crit_beat = 0;
    end else begin
      exp_a = '{32'h0600_0000, 32'h0600_0004, 32'h0600_0008, 32'h0600_000C};
      exp_crit = 32'hF3; exp_crit_beat = 3;
    end
    issue(32'h0600_000C, 1'b1, 2'd3);
    for (int b = 0; b < 4; b++) begin
      n_cmp++; if (DBUS_A !== exp_a[b]) begin n_err++; $display("FAIL order_beat%0d: got %h want %h", b, DBUS_A, exp_a[b]); end
      DBUS_DI = 32'hF0 + b; step();
      if (CRIT_VALID) crit_at = b;
      if (LINE_VALID) line_at = b;
    end
    DBUS_DI = '0;
    n_cmp++; if (crit_at !== exp_crit_beat || line_at !== 3)
      begin n_err++; $display("FAIL order_pulses: got crit_beat=%0d line_beat=%0d want %0d 3", crit_at, line_at, exp_crit_beat); end
    n_cmp++; if (CRIT_DATA !== exp_crit) begin n_err++; $display("FAIL order_crit_data: got %h want %h", CRIT_DATA, exp_crit); end
    step();
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b1; MISS_REQ = 1'b0; MISS_A = '0; MISS_CACHEABLE = 1'b0;
    MISS_WAY = '0; ABORT = 1'b0; DBUS_DI = '0; DBUS_BUSY = 1'b0;
    test_reset();
    test_cacheable();
    test_noncacheable();
    test_bus_stall();
    test_ce_hold();
    test_abort();
    test_reset_mid_fill();
    test_crit_order();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
